// File: rtl/dbus_router.sv
// ---------------------------------------------------------------------------
// dbus_router
//
// Data-bus interconnect between the pipeline CPU's DMEM port and NSLV
// memory-mapped slaves. Each CPU access is decoded by base/mask, the address
// is rebased to a slave-relative offset, and a req/ack handshake is run with
// the selected slave while the pipeline is stalled. Slaves may insert any
// number of wait states by delaying their ack.
//
// Transaction flow: IDLE -> ACCESS (until ack) -> DONE (one cycle) -> IDLE.
// An unmapped access skips ACCESS and completes in DONE with an error.
//
// Optional feature macro: DBUS_TIMEOUT_EN
//   When defined, an ACCESS that sees no ack for TIMEOUT cycles is abandoned
//   and completes with cpu_err=1 and cpu_rdata=32'hDEADBEEF. When undefined,
//   ACCESS waits for the ack indefinitely.
//
// Parameters
//   NSLV      number of slave ports
//   AW, DW    address / data width
//   SLV_BASE  NSLV*AW flat vector, slave i base at [i*AW +: AW]
//   SLV_MASK  NSLV*AW flat vector, compared address bits for slave i
//   TIMEOUT   max ACCESS cycles without ack (DBUS_TIMEOUT_EN only)
//
// Ports
//   clock      in   1        system clock, posedge
//   reset      in   1        synchronous, active-high
//   cpu_req    in   1        load/store request, held stable while stalled
//   cpu_we     in   1        1=store, 0=load
//   cpu_addr   in   AW       byte address
//   cpu_wdata  in   DW       store data
//   cpu_stall  out  1        freeze pipeline (combinational)
//   cpu_rdata  out  DW       load data, valid in DONE, held until next capture
//   cpu_err    out  1        decode/timeout error, valid in DONE, held
//   slv_sel    out  NSLV     one-hot request strobe, held until ack
//   slv_we     out  1        registered write enable
//   slv_addr   out  AW       cpu_addr - SLV_BASE[sel], modulo 2^AW
//   slv_wdata  out  DW       registered store data
//   slv_ack    in   NSLV     per-slave completion; only the selected bit counts
//   slv_rdata  in   NSLV*DW  flat read data, slave i at [i*DW +: DW]
// ---------------------------------------------------------------------------
module dbus_router #(
  parameter int unsigned           NSLV     = 2,
  parameter int unsigned           AW       = 32,
  parameter int unsigned           DW       = 32,
  parameter logic [NSLV*AW-1:0]    SLV_BASE = {32'h10020000, 32'h10010000},
  parameter logic [NSLV*AW-1:0]    SLV_MASK = {32'hFFFFF000, 32'hFFFF0000},
  parameter int unsigned           TIMEOUT  = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_wdata,
  output logic                 cpu_stall,
  output logic [DW-1:0]        cpu_rdata,
  output logic                 cpu_err,
  output logic [NSLV-1:0]      slv_sel,
  output logic                 slv_we,
  output logic [AW-1:0]        slv_addr,
  output logic [DW-1:0]        slv_wdata,
  input  logic [NSLV-1:0]      slv_ack,
  input  logic [NSLV*DW-1:0]   slv_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  // -------------------------------------------------------------------------
  // Address decode: first (lowest-index) matching slave wins on overlap.
  // -------------------------------------------------------------------------
  logic            dec_hit;
  logic [NSLV-1:0] dec_onehot;
  logic [AW-1:0]   dec_base;

  always_comb begin
    dec_hit    = 1'b0;
    dec_onehot = '0;
    dec_base   = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!dec_hit &&
          ((cpu_addr & SLV_MASK[i*AW +: AW]) ==
           (SLV_BASE[i*AW +: AW] & SLV_MASK[i*AW +: AW]))) begin
        dec_hit       = 1'b1;
        dec_onehot[i] = 1'b1;
        dec_base      = SLV_BASE[i*AW +: AW];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Ack / read-data from the currently selected slave. slv_sel is one-hot
  // while in ACCESS, so an OR-mux is sufficient.
  // -------------------------------------------------------------------------
  logic          ack_hit;
  logic [DW-1:0] rdata_sel;

  always_comb begin
    ack_hit   = |(slv_ack & slv_sel);
    rdata_sel = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (slv_sel[i]) begin
        rdata_sel = rdata_sel | slv_rdata[i*DW +: DW];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional ACCESS watchdog. The count is the number of ack-less ACCESS
  // cycles already elapsed, so the watchdog fires in the TIMEOUT-th cycle.
  // -------------------------------------------------------------------------
`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  always_comb begin
    to_hit = (to_cnt == TO_LAST);
  end
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and stall
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cpu_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          cpu_stall  = 1'b1;
          state_next = dec_hit ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        cpu_stall = 1'b1;
        if (ack_hit) begin
          state_next = DONE;
        end
`ifdef DBUS_TIMEOUT_EN
        else if (to_hit) begin
          state_next = DONE;
        end
`endif
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      slv_sel   <= '0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (dec_hit) begin
              slv_sel   <= dec_onehot;
              slv_we    <= cpu_we;
              slv_addr  <= cpu_addr - dec_base;
              slv_wdata <= cpu_wdata;
`ifdef DBUS_TIMEOUT_EN
              to_cnt    <= '0;
`endif
            end else begin
              // Unmapped: no strobe is raised, so a store is simply dropped.
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          // Ack takes priority over a watchdog expiry in the same cycle.
          if (ack_hit) begin
            cpu_rdata <= rdata_sel;
            cpu_err   <= 1'b0;
            slv_sel   <= '0;
          end
`ifdef DBUS_TIMEOUT_EN
          else if (to_hit) begin
            cpu_rdata <= DW'(32'hDEADBEEF);
            cpu_err   <= 1'b1;
            slv_sel   <= '0;
          end else begin
            to_cnt    <= to_cnt + 1'b1;
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_router.sv
// ---------------------------------------------------------------------------
// tb_dbus_router
//
// Self-checking bench for dbus_router. The bench plays the CPU and all
// slaves. Each transaction's outcome (selected slave, offset, stall length,
// returned data, error) is predicted from the address map and the chosen
// ack delay. Slave 1's mask is widened so that slave 0's window also lies
// inside slave 1's, exercising lowest-index priority and offset wrap.
// ---------------------------------------------------------------------------
module tb_dbus_router;

  localparam int NSLV    = 2;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;
  localparam logic [NSLV*AW-1:0] BASE = {32'h10020000, 32'h10010000};
  localparam logic [NSLV*AW-1:0] MASK = {32'hFF000000, 32'hFFFF0000};

  logic                clock = 1'b0;
  logic                reset;
  logic                cpu_req;
  logic                cpu_we;
  logic [AW-1:0]       cpu_addr;
  logic [DW-1:0]       cpu_wdata;
  logic                cpu_stall;
  logic [DW-1:0]       cpu_rdata;
  logic                cpu_err;
  logic [NSLV-1:0]     slv_sel;
  logic                slv_we;
  logic [AW-1:0]       slv_addr;
  logic [DW-1:0]       slv_wdata;
  logic [NSLV-1:0]     slv_ack;
  logic [NSLV*DW-1:0]  slv_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] last_rdata;
  logic          last_err;

  dbus_router #(
    .NSLV    (NSLV),
    .AW      (AW),
    .DW      (DW),
    .SLV_BASE(BASE),
    .SLV_MASK(MASK),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall),
    .cpu_rdata(cpu_rdata),
    .cpu_err  (cpu_err),
    .slv_sel  (slv_sel),
    .slv_we   (slv_we),
    .slv_addr (slv_addr),
    .slv_wdata(slv_wdata),
    .slv_ack  (slv_ack),
    .slv_rdata(slv_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Address map reference: scan from highest index down so the lowest
  // matching index is the one left standing.
  function automatic int model_decode(input logic [AW-1:0] a);
    int idx = -1;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((a & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW])) idx = i;
    end
    return idx;
  endfunction

  function automatic logic [NSLV*DW-1:0] rand_rdata();
    return {$urandom, $urandom};
  endfunction

  // Entered and left just after a rising edge, with the DUT in IDLE.
  // delay = number of ACCESS cycles before the ack is driven.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int delay);
    int              idx;
    logic [NSLV-1:0] exp_sel;
    logic [AW-1:0]   exp_off;
    int              exp_stalls;
    logic [DW-1:0]   exp_rd;
    logic            exp_err;
    int              stalls;
    int              k;
    bit              done;
    logic [NSLV-1:0] noise;

    idx        = model_decode(addr);
    exp_sel    = '0;
    exp_off    = '0;
    exp_rd     = '0;
    exp_err    = 1'b1;
    exp_stalls = 1;
    if (idx >= 0) begin
      exp_sel[idx] = 1'b1;
      exp_off      = addr - BASE[idx*AW +: AW];
      exp_err      = 1'b0;
      exp_stalls   = delay + 2;
`ifdef DBUS_TIMEOUT_EN
      if (delay >= TIMEOUT) begin
        exp_stalls = TIMEOUT + 1;
        exp_err    = 1'b1;
        exp_rd     = 32'hDEADBEEF;
      end
`endif
    end

    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
    stalls    = 0;
    done      = 1'b0;
    k         = 0;
    while (!done && k < 200) begin
      slv_rdata = rand_rdata();
      noise     = NSLV'($urandom);
      if (k == 0) begin
        slv_ack = noise;
      end else if (idx >= 0 && (k - 1) == delay) begin
        slv_ack = exp_sel | noise;
        if (!exp_err) exp_rd = slv_rdata[idx*DW +: DW];
      end else begin
        slv_ack = noise & ~exp_sel;
      end
      @(negedge clock);
      if (k == 1 && idx >= 0) begin
        check("slv_sel", 64'(slv_sel), 64'(exp_sel));
        check("slv_we", 64'(slv_we), 64'(we));
        check("slv_addr", 64'(slv_addr), 64'(exp_off));
        if (we) check("slv_wdata", 64'(slv_wdata), 64'(wd));
      end
      if (cpu_stall) begin
        stalls++;
      end else begin
        done = 1'b1;
        check("done_rdata", 64'(cpu_rdata), 64'(exp_rd));
        check("done_err", 64'(cpu_err), 64'(exp_err));
        check("done_sel", 64'(slv_sel), 64'd0);
      end
      @(posedge clock);
      #1;
      k++;
    end
    check("reached_done", 64'(done), 64'd1);
    check("stall_cycles", 64'(stalls), 64'(exp_stalls));
    cpu_req    = 1'b0;
    slv_ack    = '0;
    last_rdata = exp_rd;
    last_err   = exp_err;
  endtask

  // Idle cycles with spurious acks: nothing may move.
  task automatic idle_cycles(input int n);
    cpu_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      slv_ack   = NSLV'($urandom);
      slv_rdata = rand_rdata();
      @(negedge clock);
      check("idle_stall", 64'(cpu_stall), 64'd0);
      check("hold_rdata", 64'(cpu_rdata), 64'(last_rdata));
      check("hold_err", 64'(cpu_err), 64'(last_err));
      @(posedge clock);
      #1;
    end
    slv_ack = '0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    case ($urandom_range(0, 3))
      0:       a = {16'h1001, 16'($urandom)};
      1:       a = {8'h10, 24'($urandom)};
      2:       a = {16'h1002, 16'($urandom)};
      default: a = {8'($urandom_range(32, 255)), 24'($urandom)};
    endcase
    return a;
  endfunction

  initial begin
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    slv_ack   = '0;
    slv_rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_sel", 64'(slv_sel), 64'd0);
    check("rst_we", 64'(slv_we), 64'd0);
    check("rst_addr", 64'(slv_addr), 64'd0);
    check("rst_wdata", 64'(slv_wdata), 64'd0);
    check("rst_rdata", 64'(cpu_rdata), 64'd0);
    check("rst_err", 64'(cpu_err), 64'd0);
    check("rst_stall", 64'(cpu_stall), 64'd0);
    @(posedge clock);
    #1;
    reset      = 1'b0;
    last_rdata = '0;
    last_err   = 1'b0;

    // Directed cases
    run_txn(1'b0, 32'h10010004, 32'h0, 3);          // load, 3 wait states
    idle_cycles(1);
    run_txn(1'b1, 32'h10020010, 32'h12345678, 0);   // store, immediate ack
    run_txn(1'b0, 32'h00000000, 32'h0, 0);          // unmapped
    idle_cycles(2);
    run_txn(1'b0, 32'h10010000, 32'h0, 1);          // overlap, slave 0 wins
    run_txn(1'b1, 32'h10000004, 32'hA5A5A5A5, 2);   // slave 1, offset wraps
    run_txn(1'b0, 32'h10020100, 32'h0, TIMEOUT - 1); // ack on the last allowed cycle
    run_txn(1'b0, 32'h10020200, 32'h0, 30);         // long wait / timeout build
    idle_cycles(1);

    // Reset in the second ACCESS cycle
    run_txn(1'b0, 32'h40000000, 32'h0, 0);          // leaves cpu_err=1
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h10010040;
    slv_ack  = '0;
    @(negedge clock);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_mid_sel1", 64'(slv_sel), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_stall", 64'(cpu_stall), 64'd1);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    cpu_req = 1'b0;
    @(negedge clock);
    check("abort_sel", 64'(slv_sel), 64'd0);
    check("abort_stall", 64'(cpu_stall), 64'd0);
    check("abort_err", 64'(cpu_err), 64'd0);
    check("abort_addr", 64'(slv_addr), 64'd0);
    last_rdata = '0;
    last_err   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      slv_ack   = '1;
      slv_rdata = rand_rdata();
      @(negedge clock);
      check("late_ack_stall", 64'(cpu_stall), 64'd0);
      check("late_ack_rdata", 64'(cpu_rdata), 64'd0);
    end
    @(posedge clock);
    #1;
    slv_ack = '0;

    // Randomised traffic
    for (int n = 0; n < 80; n++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
      run_txn(1'($urandom), rand_addr(), $urandom, d);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
